// File: rtl/tensor_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module      : tensor_buffer_mc
// Description : Multi-channel, bank-interleaved tensor SRAM. Per-bank
//               round-robin arbitration, fixed 2-cycle response latency,
//               per-byte even parity and per-bank power-gating FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module tensor_buffer_mc #(
  parameter  int NUM_CH      = 2,
  parameter  int NUM_BANKS   = 4,
  parameter  int DATA_WIDTH  = 128,
  parameter  int BANK_DEPTH  = 1024,
  parameter  int WAKE_CYCLES = 8,
  localparam int ADDR_WIDTH  = $clog2(NUM_BANKS * BANK_DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              req_valid_i,
  output logic [NUM_CH-1:0]              req_ready_o,
  input  logic [NUM_CH-1:0]              req_we_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] req_wmask_i,
  output logic [NUM_CH-1:0]              rsp_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [NUM_CH-1:0]              rsp_err_o,
  input  logic [NUM_BANKS-1:0]           bank_gate_i,
  output logic [NUM_BANKS-1:0]           bank_on_o,
  output logic                           power_ok_o,
  input  logic                           err_inj_i,
  input  logic                           err_clr_i,
  output logic                           par_err_o,
  output logic [7:0]                     par_err_count_o
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(WAKE_CYCLES + 1);

  typedef enum logic [1:0] {
    PWR_ON     = 2'd0,
    PWR_GATING = 2'd1,
    PWR_OFF    = 2'd2,
    PWR_WAKING = 2'd3
  } pwr_state_e;

  function automatic int rr_idx(input logic [CH_W-1:0] ptr, input int k);
    return (int'(ptr) + k) % NUM_CH;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [BANK_W-1:0] w_ch_bank [NUM_CH];
  logic [ROW_W-1:0]  w_ch_row  [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch_dec
    assign w_ch_bank[c] = req_addr_i[c*ADDR_WIDTH +: BANK_W];
    assign w_ch_row[c]  = req_addr_i[c*ADDR_WIDTH+BANK_W +: ROW_W];
  end

  // ---------------------------------------------------------- power FSMs
  pwr_state_e           r_pwr_state    [NUM_BANKS];
  pwr_state_e           w_pwr_next     [NUM_BANKS];
  logic [CNT_W-1:0]     r_pwr_cnt      [NUM_BANKS];
  logic [CNT_W-1:0]     w_pwr_cnt_next [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_bank_open, w_bank_off, w_pwr_match;
  logic                 r_power_ok;

  // Next-state logic; a bank is open when ON and not being gated, or when OFF
  // (OFF accesses are accepted and answered with an error).
  always_comb begin
    w_bank_open = '0;
    w_bank_off  = '0;
    w_pwr_match = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_pwr_next[b]     = r_pwr_state[b];
      w_pwr_cnt_next[b] = r_pwr_cnt[b];
      unique case (r_pwr_state[b])
        PWR_ON: if (bank_gate_i[b]) begin
          w_pwr_next[b]     = PWR_GATING;
          w_pwr_cnt_next[b] = CNT_W'(1);
        end
        PWR_GATING: begin
          if (r_pwr_cnt[b] == '0) w_pwr_next[b] = PWR_OFF;
          else                    w_pwr_cnt_next[b] = r_pwr_cnt[b] - CNT_W'(1);
        end
        PWR_OFF: if (!bank_gate_i[b]) begin
          w_pwr_next[b]     = PWR_WAKING;
          w_pwr_cnt_next[b] = CNT_W'(WAKE_CYCLES);
        end
        PWR_WAKING: begin
          w_pwr_cnt_next[b] = r_pwr_cnt[b] - CNT_W'(1);
          if (r_pwr_cnt[b] == CNT_W'(1)) w_pwr_next[b] = PWR_ON;
        end
        default: w_pwr_next[b] = PWR_ON;
      endcase
      w_pwr_match[b] = bank_gate_i[b] ? (w_pwr_next[b] == PWR_OFF)
                                      : (w_pwr_next[b] == PWR_ON);
      w_bank_off[b]  = (r_pwr_state[b] == PWR_OFF);
      w_bank_open[b] = rst_ni && (((r_pwr_state[b] == PWR_ON) && !bank_gate_i[b]) ||
                                  (r_pwr_state[b] == PWR_OFF));
    end
  end

  // Power state registers; reset forces every bank ON.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_pwr_state[b] <= PWR_ON;
        r_pwr_cnt[b]   <= '0;
      end
      r_power_ok <= 1'b1;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_pwr_state[b] <= w_pwr_next[b];
        r_pwr_cnt[b]   <= w_pwr_cnt_next[b];
      end
      r_power_ok <= &w_pwr_match;
    end
  end

  // Bank-on flags straight from the state registers.
  always_comb begin
    bank_on_o = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_on_o[b] = (r_pwr_state[b] == PWR_ON);
  end

  assign power_ok_o = r_power_ok;

  // ---------------------------------------------------------- arbitration
  logic [CH_W-1:0]      r_rr_ptr   [NUM_BANKS];
  logic [CH_W-1:0]      w_bank_win [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_bank_gnt;
  logic [NUM_CH-1:0]    w_ch_gnt;

  // Per-bank round robin: scan downward so the first channel at/after the
  // pointer is the last (winning) assignment.
  always_comb begin
    w_bank_gnt = '0;
    w_ch_gnt   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_win[b] = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (w_bank_open[b] && req_valid_i[rr_idx(r_rr_ptr[b], k)] &&
            (w_ch_bank[rr_idx(r_rr_ptr[b], k)] == BANK_W'(b))) begin
          w_bank_win[b] = CH_W'(rr_idx(r_rr_ptr[b], k));
          w_bank_gnt[b] = 1'b1;
        end
      end
      if (w_bank_gnt[b]) w_ch_gnt[w_bank_win[b]] = 1'b1;
    end
  end

  assign req_ready_o = w_ch_gnt;

  // Pointer moves past the winner on every grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int b = 0; b < NUM_BANKS; b++) r_rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++)
        if (w_bank_gnt[b]) r_rr_ptr[b] <= CH_W'((int'(w_bank_win[b]) + 1) % NUM_CH);
    end
  end

  // ------------------------------------------------------- bank datapath
  logic [ROW_W-1:0]      w_bank_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_bank_wdata [NUM_BANKS];
  logic [NB-1:0]         w_bank_wmask [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_bank_we;

  // Route the winning channel's request fields to each bank.
  always_comb begin
    w_bank_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_row[b]   = w_ch_row[w_bank_win[b]];
      w_bank_we[b]    = req_we_i[w_bank_win[b]];
      w_bank_wdata[b] = req_wdata_i[int'(w_bank_win[b])*DATA_WIDTH +: DATA_WIDTH];
      w_bank_wmask[b] = req_wmask_i[int'(w_bank_win[b])*NB +: NB];
    end
  end

  logic [DATA_WIDTH-1:0] w_s1_data [NUM_BANKS];
  logic [NUM_BANKS-1:0]  w_s1_mism;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [BANK_DEPTH];
    logic [NB-1:0]         r_par [BANK_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [NB-1:0]         r_rpar;
    logic [NB-1:0]         w_calc_par;
    logic                  w_access;

    assign w_access = w_bank_gnt[b] && !w_bank_off[b];

    // Single-port array: masked byte writes with even parity, or a read.
    always_ff @(posedge clk_i) begin
      if (w_access && w_bank_we[b]) begin
        for (int i = 0; i < NB; i++) begin
          if (w_bank_wmask[b][i]) begin
            r_mem[w_bank_row[b]][i*8 +: 8] <= w_bank_wdata[b][i*8 +: 8];
            r_par[w_bank_row[b]][i]        <= (^w_bank_wdata[b][i*8 +: 8]) ^ (err_inj_i && (i == 0));
          end
        end
      end
      if (w_access && !w_bank_we[b]) begin
        r_rdata <= r_mem[w_bank_row[b]];
        r_rpar  <= r_par[w_bank_row[b]];
      end
    end

    for (genvar i = 0; i < NB; i++) begin : g_par
      assign w_calc_par[i] = ^r_rdata[i*8 +: 8];
    end

    assign w_s1_data[b] = r_rdata;
    assign w_s1_mism[b] = |(w_calc_par ^ r_rpar);
  end

  // ------------------------------------------------------ response pipe
  logic [NUM_BANKS-1:0] r_s1_valid, r_s1_we, r_s1_off;
  logic [CH_W-1:0]      r_s1_ch [NUM_BANKS];

  // Stage 1: remember who owns each bank's in-flight operation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_valid <= '0;
      r_s1_we    <= '0;
      r_s1_off   <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_s1_ch[b] <= '0;
    end else begin
      r_s1_valid <= w_bank_gnt;
      r_s1_we    <= w_bank_we;
      r_s1_off   <= w_bank_off;
      for (int b = 0; b < NUM_BANKS; b++) r_s1_ch[b] <= w_bank_win[b];
    end
  end

  logic [NUM_BANKS-1:0]         w_s1_perr;
  logic [NUM_CH-1:0]            w_rsp_valid, w_rsp_err;
  logic [NUM_CH*DATA_WIDTH-1:0] w_rsp_rdata;

  // Stage 2: parity check and bank-to-channel routing; a channel holds at
  // most one grant per cycle, so no two banks answer the same channel.
  always_comb begin
    w_s1_perr   = '0;
    w_rsp_valid = '0;
    w_rsp_err   = '0;
    w_rsp_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_s1_perr[b] = r_s1_valid[b] && !r_s1_we[b] && !r_s1_off[b] && w_s1_mism[b];
      if (r_s1_valid[b]) begin
        w_rsp_valid[r_s1_ch[b]] = 1'b1;
        w_rsp_err[r_s1_ch[b]]   = r_s1_off[b] || w_s1_perr[b];
        if (!r_s1_we[b] && !r_s1_off[b])
          w_rsp_rdata[int'(r_s1_ch[b])*DATA_WIDTH +: DATA_WIDTH] = w_s1_data[b];
      end
    end
  end

  logic [NUM_CH-1:0]            r_rsp_valid, r_rsp_err;
  logic [NUM_CH*DATA_WIDTH-1:0] r_rsp_rdata;
  logic                         r_par_err;
  logic [7:0]                   r_err_cnt;

  // Response registers and saturating parity-error counter (clear wins).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_rdata <= '0;
      r_par_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_par_err   <= |w_s1_perr;
      if (err_clr_i)                          r_err_cnt <= '0;
      else if (|w_s1_perr && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_err_o       = r_rsp_err;
  assign rsp_rdata_o     = r_rsp_rdata;
  assign par_err_o       = r_par_err;
  assign par_err_count_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tensor_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_tensor_buffer_mc
// Description : Self-checking bench for tensor_buffer_mc against a
//               transaction-level reference model (byte-array memory with
//               corrupted-byte flags, per-bank power phases, RR pointers).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tensor_buffer_mc;

  localparam int NCH  = 2;
  localparam int NBK  = 4;
  localparam int DW   = 128;
  localparam int DEP  = 1024;
  localparam int WAKE = 8;
  localparam int AW   = 12;
  localparam int NBY  = DW / 8;

  localparam int ST_ON = 0, ST_GATING = 1, ST_OFF = 2, ST_WAKING = 3;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [NCH-1:0]      req_valid_i = '0, req_we_i = '0, req_ready_o;
  logic [NCH*AW-1:0]   req_addr_i = '0;
  logic [NCH*DW-1:0]   req_wdata_i = '0;
  logic [NCH*NBY-1:0]  req_wmask_i = '0;
  logic [NCH-1:0]      rsp_valid_o, rsp_err_o;
  logic [NCH*DW-1:0]   rsp_rdata_o;
  logic [NBK-1:0]      bank_gate_i = '0, bank_on_o;
  logic                power_ok_o, err_inj_i = 1'b0, err_clr_i = 1'b0, par_err_o;
  logic [7:0]          par_err_count_o;

  tensor_buffer_mc #(
    .NUM_CH(NCH), .NUM_BANKS(NBK), .DATA_WIDTH(DW), .BANK_DEPTH(DEP), .WAKE_CYCLES(WAKE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .bank_gate_i(bank_gate_i), .bank_on_o(bank_on_o), .power_ok_o(power_ok_o),
    .err_inj_i(err_inj_i), .err_clr_i(err_clr_i), .par_err_o(par_err_o),
    .par_err_count_o(par_err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  int              m_st [NBK];
  int              m_left [NBK];
  int              m_ptr [NBK];
  logic [DW-1:0]   m_mem [int];
  logic [NBY-1:0]  m_bad [int];
  bit              p_v [NCH], p_e [NCH], p_pe [NCH];
  logic [DW-1:0]   p_d [NCH];
  bit              v_v [NCH], v_e [NCH], v_pe [NCH];
  logic [DW-1:0]   v_d [NCH];
  int              m_cnt;
  bit              m_pok;

  function automatic int ch_addr(input int c);
    return int'(req_addr_i[c*AW +: AW]);
  endfunction

  function automatic logic [NCH-1:0] model_ready();
    logic [NCH-1:0] r;
    bit open, found;
    int c;
    r = '0;
    if (rst_ni) begin
      for (int b = 0; b < NBK; b++) begin
        open  = (m_st[b] == ST_ON && !bank_gate_i[b]) || (m_st[b] == ST_OFF);
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr[b] + k) % NCH;
          if (open && !found && req_valid_i[c] && (ch_addr(c) % NBK == b)) begin
            r[c]  = 1'b1;
            found = 1;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NBK; b++) begin
      m_st[b] = ST_ON; m_left[b] = 0; m_ptr[b] = 0;
    end
    for (int c = 0; c < NCH; c++) begin
      p_v[c] = 0; p_e[c] = 0; p_pe[c] = 0; p_d[c] = '0;
      v_v[c] = 0; v_e[c] = 0; v_pe[c] = 0; v_d[c] = '0;
    end
    m_cnt = 0;
    m_pok = 1;
  endtask

  // One clock: check ready, advance model at the edge, check outputs after.
  task automatic cycle();
    logic [NCH-1:0] er;
    int  a, b;
    bit  any_pe, was_rst;
    int  keys[$];
    #1;
    er = model_ready();
    check_val("req_ready", DW'(req_ready_o), DW'(er));
    @(posedge clk_i);
    was_rst = !rst_ni;
    if (was_rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        v_v[c] = p_v[c]; v_e[c] = p_e[c]; v_pe[c] = p_pe[c]; v_d[c] = p_d[c];
        p_v[c] = 0; p_e[c] = 0; p_pe[c] = 0; p_d[c] = '0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (er[c]) begin
          a = ch_addr(c);
          b = a % NBK;
          p_v[c] = 1;
          if (m_st[b] == ST_OFF) begin
            p_e[c] = 1;
          end else if (req_we_i[c]) begin
            if (!m_mem.exists(a)) begin m_mem[a] = '0; m_bad[a] = '0; end
            for (int i = 0; i < NBY; i++) begin
              if (req_wmask_i[c*NBY + i]) begin
                m_mem[a][i*8 +: 8] = req_wdata_i[c*DW + i*8 +: 8];
                m_bad[a][i]        = (i == 0) && err_inj_i;
              end
            end
          end else begin
            p_d[c]  = m_mem[a];
            p_pe[c] = |m_bad[a];
            p_e[c]  = p_pe[c];
          end
          m_ptr[b] = (c + 1) % NCH;
        end
      end
      m_pok = 1;
      for (int bb = 0; bb < NBK; bb++) begin
        case (m_st[bb])
          ST_ON:     if (bank_gate_i[bb]) begin m_st[bb] = ST_GATING; m_left[bb] = 2; end
          ST_GATING: begin
            m_left[bb]--;
            if (m_left[bb] == 0) begin
              m_st[bb] = ST_OFF;
              keys.delete();
              foreach (m_mem[k]) if (k % NBK == bb) keys.push_back(k);
              foreach (keys[i]) begin m_mem.delete(keys[i]); m_bad.delete(keys[i]); end
            end
          end
          ST_OFF:    if (!bank_gate_i[bb]) begin m_st[bb] = ST_WAKING; m_left[bb] = WAKE; end
          default: begin
            m_left[bb]--;
            if (m_left[bb] == 0) m_st[bb] = ST_ON;
          end
        endcase
        if (bank_gate_i[bb] ? (m_st[bb] != ST_OFF) : (m_st[bb] != ST_ON)) m_pok = 0;
      end
      any_pe = 0;
      for (int c = 0; c < NCH; c++) any_pe |= v_pe[c];
      if (err_clr_i)                    m_cnt = 0;
      else if (any_pe && m_cnt < 255)   m_cnt++;
    end
    #1;
    any_pe = 0;
    for (int c = 0; c < NCH; c++) begin
      any_pe |= v_pe[c];
      check_val($sformatf("rsp_valid[%0d]", c), DW'(rsp_valid_o[c]), DW'(v_v[c]));
      if (v_v[c] || was_rst) begin
        check_val($sformatf("rsp_err[%0d]", c), DW'(rsp_err_o[c]), DW'(v_e[c]));
        check_val($sformatf("rsp_rdata[%0d]", c), rsp_rdata_o[c*DW +: DW], v_d[c]);
      end
    end
    for (int bb = 0; bb < NBK; bb++)
      check_val($sformatf("bank_on[%0d]", bb), DW'(bank_on_o[bb]), DW'(m_st[bb] == ST_ON));
    check_val("power_ok", DW'(power_ok_o), DW'(m_pok));
    check_val("par_err", DW'(par_err_o), DW'(any_pe));
    check_val("par_err_count", DW'(par_err_count_o), DW'(m_cnt));
  endtask

  // ------------------------------------------------------ stimulus helpers
  task automatic set_req(input int c, input bit v, input bit we, input int addr,
                         input logic [DW-1:0] d, input logic [NBY-1:0] m);
    req_valid_i[c]            = v;
    req_we_i[c]               = we;
    req_addr_i[c*AW +: AW]    = AW'(addr);
    req_wdata_i[c*DW +: DW]   = d;
    req_wmask_i[c*NBY +: NBY] = m;
  endtask

  task automatic idle(input int n);
    req_valid_i = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [DW-1:0] rd;
    int            addr;
    bit            we;
    logic [NBY-1:0] msk;
    model_reset();

    // Reset state
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;

    // Single-channel write then read of address 5
    set_req(0, 1, 1, 5, {16{8'hA5}}, '1); cycle();
    set_req(0, 1, 0, 5, '0, '0);          cycle();
    idle(2);

    // Partial mask on address 9
    set_req(0, 1, 1, 9, '1, '1);             cycle();
    set_req(0, 1, 1, 9, '0, NBY'(16'h0001)); cycle();
    set_req(0, 1, 0, 9, '0, '0);             cycle();
    idle(2);

    // Bank conflict on bank 1, then disjoint banks 1 and 2
    set_req(0, 1, 0, 5, '0, '0);
    set_req(1, 1, 0, 9, '0, '0);
    for (int i = 0; i < 4; i++) cycle();
    set_req(1, 1, 1, 2, {4{32'h1234_5678}}, '1);
    cycle();
    idle(2);

    // Parity injection on address 6, three reads, then clear
    err_inj_i = 1'b1;
    set_req(0, 1, 1, 6, {4{32'hDEAD_BEEF}}, '1); cycle();
    err_inj_i = 1'b0;
    set_req(0, 1, 0, 6, '0, '0);
    for (int i = 0; i < 3; i++) cycle();
    idle(2);
    err_clr_i = 1'b1; cycle(); err_clr_i = 1'b0;

    // Counter saturation: 300 consecutive parity-error responses
    set_req(0, 1, 0, 6, '0, '0);
    for (int i = 0; i < 300; i++) cycle();
    idle(3);
    err_clr_i = 1'b1; cycle(); err_clr_i = 1'b0;

    // Gate bank 2 with a pending ch0 read; access while OFF; wake up again
    bank_gate_i[2] = 1'b1;
    set_req(0, 1, 0, 6, '0, '0);
    for (int i = 0; i < 4; i++) cycle();
    idle(2);
    bank_gate_i[2] = 1'b0;
    set_req(0, 1, 1, 6, {8{16'hC0DE}}, '1);
    for (int i = 0; i < WAKE + 3; i++) cycle();
    set_req(0, 1, 0, 6, '0, '0); cycle();
    idle(2);

    // Reset one edge after a read is accepted; gate right after reset
    set_req(0, 1, 0, 5, '0, '0); cycle();
    req_valid_i = '0;
    rst_ni = 1'b0; cycle();
    bank_gate_i[0] = 1'b1; cycle();
    rst_ni = 1'b1; cycle();
    bank_gate_i[0] = 1'b0;
    idle(WAKE + 6);

    // Randomized traffic with occasional gating, injection and clears
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NCH; c++) begin
        addr = int'($urandom_range(0, 15));
        we   = 1'($urandom_range(0, 1));
        msk  = {$urandom, $urandom} == 64'd0 ? '1 : NBY'($urandom);
        if (!m_mem.exists(addr)) begin we = 1; msk = '1; end
        rd = {$urandom, $urandom, $urandom, $urandom};
        set_req(c, $urandom_range(0, 3) != 0, we, addr, rd, msk);
      end
      for (int b = 0; b < NBK; b++)
        if ($urandom_range(0, 39) == 0) bank_gate_i[b] = ~bank_gate_i[b];
      err_inj_i = ($urandom_range(0, 7) == 0);
      err_clr_i = ($urandom_range(0, 15) == 0);
      cycle();
    end
    bank_gate_i = '0;
    err_inj_i   = 1'b0;
    err_clr_i   = 1'b0;
    idle(WAKE + 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
